espectro_sequencer: RTL and testbench

- J1 bus peripheral directly upstream of the espectro tone generator.
- CPU queues notes, each a (frequency word, duration in ms) pair, into a small FIFO and issues start.
- The block pops notes in order, drives the tone word and a load strobe into espectro, holds each note for its duration, then advances.
- Frees the CPU from timing melodies note-by-note.

---
 rtl/espectro_pkg.sv | 44 ++++
 rtl/espectro_if.sv | 22 ++
 rtl/espectro_note_fifo.sv | 56 +++++
 rtl/espectro_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_espectro_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/espectro_pkg.sv
// espectro_sequencer shared definitions: register map, control and
// status bit positions, FSM encoding.
package espectro_pkg;

   localparam logic [3:0] ADDR_FREQ = 4'h2;
   localparam logic [3:0] ADDR_PUSH = 4'h4;
   localparam logic [3:0] ADDR_CTRL = 4'h6;
   localparam logic [3:0] ADDR_STAT = 4'h8;
   localparam logic [3:0] ADDR_REM  = 4'hA;

   localparam int CTRL_START   = 0;
   localparam int CTRL_STOP    = 1;
   localparam int CTRL_CLR_OVF = 2;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_OVF   = 3;
   localparam int ST_CNT   = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY
   } state_e;

   function automatic logic [15:0] status_word(
      input logic [3:0] cnt,
      input logic       ovf,
      input logic       empty,
      input logic       full,
      input logic       busy
   );
      logic [15:0] s;
      s               = '0;
      s[ST_CNT+:4]    = cnt;
      s[ST_OVF]       = ovf;
      s[ST_EMPTY]     = empty;
      s[ST_FULL]      = full;
      s[ST_BUSY]      = busy;
      return s;
   endfunction

endpackage

// File: rtl/espectro_if.sv
// CPU-side register bus of the espectro sequencer.
// The CPU is the master, the sequencer the slave.
interface espectro_if;

   logic [15:0] d_in;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;

   modport master (
      output d_in, cs, addr, rd, wr,
      input  d_out
   );

   modport slave (
      input  d_in, cs, addr, rd, wr,
      output d_out
   );

endinterface

// File: rtl/espectro_note_fifo.sv
// Note queue: 32-bit {freq, dur} entries, DEPTH deep, with flush.
// Pushes when full and pops when empty are ignored.
module espectro_note_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/espectro_sequencer.sv
// Melody sequencer: pops queued notes and drives espectro's tone word,
// load strobe and mute, holding each note for dur ticks.
module espectro_sequencer
   import espectro_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1000,
   parameter int DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   espectro_if.slave   bus,
   output logic [15:0] tone_freq,
   output logic        tone_load,
   output logic        tone_mute,
   output logic        busy
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   state_e        state_q;
   logic          run_q;
   logic [15:0]   freq_q;
   logic          ovf_q;
   logic [15:0]   tone_freq_q;
   logic          tone_load_q;
   logic          tone_mute_q;
   logic          busy_q;
   logic [15:0]   cnt_q;
   logic [PW-1:0] pre_q;
   logic [15:0]   d_out_q;
   logic [15:0]   d_out_d;

   logic          wr_en;
   logic          rd_en;
   logic          wr_freq;
   logic          wr_push;
   logic          wr_ctrl;
   logic          ctrl_start;
   logic          ctrl_stop;
   logic          ctrl_clr;

   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_cnt;
   logic [31:0]   head;
   logic [15:0]   head_freq;
   logic [15:0]   head_dur;
   logic          push_ok;
   logic          pop;
   logic          more_after_pop;
   logic          more_now;

   assign wr_en   = bus.cs & bus.wr;
   assign rd_en   = bus.cs & bus.rd;
   assign wr_freq = wr_en & (bus.addr == ADDR_FREQ);
   assign wr_push = wr_en & (bus.addr == ADDR_PUSH);
   assign wr_ctrl = wr_en & (bus.addr == ADDR_CTRL);

   assign ctrl_start = wr_ctrl & bus.d_in[CTRL_START];
   assign ctrl_stop  = wr_ctrl & bus.d_in[CTRL_STOP];
   assign ctrl_clr   = wr_ctrl & bus.d_in[CTRL_CLR_OVF];

   assign head_freq = head[31:16];
   assign head_dur  = head[15:0];
   assign push_ok   = wr_push & ~fifo_full;
   assign pop       = (state_q == S_LOAD) & ~ctrl_stop;

   // A push landing in the same clk keeps the queue non-empty.
   assign more_after_pop = (fifo_cnt > CW'(1)) | push_ok;
   assign more_now       = ~fifo_empty | push_ok;

   espectro_note_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_push),
      .pop_i   (pop),
      .flush_i (ctrl_stop),
      .wdata_i ({freq_q, bus.d_in}),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freq_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_freq) freq_q <= bus.d_in;
         if (wr_push & fifo_full) ovf_q <= 1'b1;
         else if (ctrl_clr)       ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         run_q       <= 1'b0;
         tone_freq_q <= '0;
         tone_load_q <= 1'b0;
         tone_mute_q <= 1'b1;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         pre_q       <= '0;
      end else begin
         tone_load_q <= 1'b0;
         busy_q      <= (state_q != S_IDLE);
         unique case (state_q)
            S_IDLE: begin
               if (run_q) begin
                  if (!fifo_empty) state_q <= S_LOAD;
                  else             run_q   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (head_dur == '0) begin
                  if (more_after_pop) begin
                     state_q <= S_LOAD;
                  end else begin
                     state_q     <= S_IDLE;
                     tone_mute_q <= 1'b1;
                     run_q       <= 1'b0;
                  end
               end else begin
                  tone_freq_q <= head_freq;
                  tone_load_q <= 1'b1;
                  tone_mute_q <= (head_freq == '0);
                  cnt_q       <= head_dur;
                  pre_q       <= '0;
                  state_q     <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (pre_q == PW'(TICK_DIV - 1)) begin
                  pre_q <= '0;
                  cnt_q <= cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     if (more_now) begin
                        state_q <= S_LOAD;
                     end else begin
                        state_q     <= S_IDLE;
                        tone_mute_q <= 1'b1;
                        run_q       <= 1'b0;
                     end
                  end
               end else begin
                  pre_q <= pre_q + PW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (ctrl_start) run_q <= 1'b1;
         // Stop wins over everything, including a start in the same write.
         if (ctrl_stop) begin
            run_q       <= 1'b0;
            state_q     <= S_IDLE;
            tone_mute_q <= 1'b1;
            tone_load_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            pre_q       <= '0;
         end
      end
   end

   always_comb begin
      d_out_d = '0;
      if (rd_en) begin
         case (bus.addr)
            ADDR_STAT: d_out_d = status_word(4'(fifo_cnt), ovf_q,
                                             fifo_empty, fifo_full,
                                             busy_q);
            ADDR_REM:  d_out_d = cnt_q;
            default:   d_out_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_out_q <= '0;
      else     d_out_q <= d_out_d;
   end

   assign bus.d_out = d_out_q;
   assign tone_freq = tone_freq_q;
   assign tone_load = tone_load_q;
   assign tone_mute = tone_mute_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_espectro_sequencer.sv
// Directed bench for espectro_sequencer with TICK_DIV = 10.
// Expected values are hand-derived cycle counts and register words.
module tb_espectro_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] tone_freq;
   logic        tone_load;
   logic        tone_mute;
   logic        busy;

   int total;
   int bad;

   espectro_if bus ();

   espectro_sequencer #(
      .CLK_HZ  (1000),
      .TICK_HZ (100),
      .DEPTH   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .tone_freq (tone_freq),
      .tone_load (tone_load),
      .tone_mute (tone_mute),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
      bus.cs   = 1'b1;
      bus.wr   = 1'b1;
      bus.addr = a;
      bus.d_in = d;
      tick();
      bus.cs = 1'b0;
      bus.wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
      bus.cs   = 1'b1;
      bus.rd   = 1'b1;
      bus.addr = a;
      tick();
      bus.cs = 1'b0;
      bus.rd = 1'b0;
      v = bus.d_out;
   endtask

   task automatic push(input logic [15:0] f, input logic [15:0] d);
      wr_reg(4'h2, f);
      wr_reg(4'h4, d);
   endtask

   // Clocks until tone_load is seen (at least one), bounded.
   task automatic wait_load(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!tone_load && n < max);
   endtask

   task automatic wait_idle(input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < max);
   endtask

   logic [15:0] v;
   int          n;
   int          loads;
   int          busys;

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      bus.cs   = 1'b0;
      bus.rd   = 1'b0;
      bus.wr   = 1'b0;
      bus.addr = '0;
      bus.d_in = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      check("rst_freq", 32'(tone_freq), 32'h0);
      check("rst_load", 32'(tone_load), 32'h0);
      check("rst_mute", 32'(tone_mute), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_dout", 32'(bus.d_out), 32'h0);
      rd_reg(4'h8, v);
      check("rst_stat", 32'(v), 32'h0004);
      tick();
      check("dout_idle", 32'(bus.d_out), 32'h0);

      // 1: two notes back to back
      push(16'd100, 16'd3);
      push(16'd500, 16'd2);
      wr_reg(4'h6, 16'h0001);
      wait_load(10, n);
      check("t1_lat1", 32'(n), 32'd2);
      check("t1_freq1", 32'(tone_freq), 32'd100);
      check("t1_mute1", 32'(tone_mute), 32'h0);
      check("t1_busy1", 32'(busy), 32'h1);
      wait_load(60, n);
      check("t1_gap", 32'(n), 32'd31);
      check("t1_freq2", 32'(tone_freq), 32'd500);
      wait_idle(60, n);
      check("t1_tail", 32'(n), 32'd21);
      check("t1_mute_end", 32'(tone_mute), 32'h1);
      check("t1_hold", 32'(tone_freq), 32'd500);

      // 2: overflow
      for (int i = 0; i < 9; i++) push(16'(i + 1), 16'd1);
      rd_reg(4'h8, v);
      check("t2_stat_full", 32'(v), 32'h008A);
      wr_reg(4'h6, 16'h0004);
      rd_reg(4'h8, v);
      check("t2_stat_clr", 32'(v), 32'h0082);
      wr_reg(4'h6, 16'h0002);
      rd_reg(4'h8, v);
      check("t2_stat_flush", 32'(v), 32'h0004);

      // 3: rest then tone
      push(16'd0, 16'd2);
      push(16'd200, 16'd1);
      wr_reg(4'h6, 16'h0001);
      wait_load(10, n);
      check("t3_lat", 32'(n), 32'd2);
      check("t3_rest_freq", 32'(tone_freq), 32'd0);
      check("t3_rest_mute", 32'(tone_mute), 32'h1);
      wait_load(60, n);
      check("t3_gap", 32'(n), 32'd21);
      check("t3_freq2", 32'(tone_freq), 32'd200);
      check("t3_mute2", 32'(tone_mute), 32'h0);
      wait_idle(60, n);
      check("t3_tail", 32'(n), 32'd11);

      // 4: stop mid-note
      push(16'd300, 16'd5);
      wr_reg(4'h6, 16'h0001);
      wait_load(10, n);
      check("t4_lat", 32'(n), 32'd2);
      rd_reg(4'hA, v);
      check("t4_rem", 32'(v), 32'd5);
      for (int i = 0; i < 13; i++) tick();
      wr_reg(4'h6, 16'h0002);
      check("t4_mute", 32'(tone_mute), 32'h1);
      check("t4_busy", 32'(busy), 32'h0);
      check("t4_hold", 32'(tone_freq), 32'd300);
      rd_reg(4'h8, v);
      check("t4_stat", 32'(v), 32'h0004);
      loads = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (tone_load) loads++;
      end
      check("t4_noload", 32'(loads), 32'd0);

      // 5: zero-duration note is skipped
      push(16'd700, 16'd0);
      push(16'd800, 16'd1);
      wr_reg(4'h6, 16'h0001);
      wait_load(10, n);
      check("t5_lat", 32'(n), 32'd3);
      check("t5_freq", 32'(tone_freq), 32'd800);
      loads = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (tone_load) loads++;
      end
      check("t5_single", 32'(loads), 32'd0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_mute", 32'(tone_mute), 32'h1);

      // 6: start on empty queue, then reset mid-note
      wr_reg(4'h6, 16'h0001);
      loads = 0;
      busys = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (tone_load) loads++;
         if (busy) busys++;
      end
      check("t6_noload", 32'(loads), 32'd0);
      check("t6_nobusy", 32'(busys), 32'd0);
      rd_reg(4'h8, v);
      check("t6_stat", 32'(v), 32'h0004);
      push(16'd900, 16'd3);
      wr_reg(4'h6, 16'h0001);
      wait_load(10, n);
      check("t6_lat", 32'(n), 32'd2);
      for (int i = 0; i < 4; i++) tick();
      rd_reg(4'h8, v);
      check("t6_stat_play", 32'(v), 32'h0005);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_mute", 32'(tone_mute), 32'h1);
      check("t6_rst_dout", 32'(bus.d_out), 32'h0);
      check("t6_rst_busy", 32'(busy), 32'h0);
      check("t6_rst_freq", 32'(tone_freq), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      rd_reg(4'h8, v);
      check("t6_post_stat", 32'(v), 32'h0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
